// File: rtl/rv32_fetch_if.sv
// Instruction-memory read port: word address and request out, ready and data back.
interface rv32_fetch_if;
   logic [31:0] instr_address_out;
   logic        instr_read_out;
   logic        instr_ready_in;
   logic [31:0] instr_read_value_in;

   modport master (
      output instr_address_out,
      output instr_read_out,
      input  instr_ready_in,
      input  instr_read_value_in
   );

   modport slave (
      input  instr_address_out,
      input  instr_read_out,
      output instr_ready_in,
      output instr_read_value_in
   );
endinterface

// File: rtl/rv32_fetch.sv
// RV32 fetch stage: hold-until-ready memory reads, static branch prediction,
// one-entry stall buffer, and redirect handling that drains an in-flight read.
module rv32_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               stall_in,
   input  logic               flush_in,
   input  logic               redirect_in,
   input  logic [31:0]        redirect_pc_in,
   rv32_fetch_if.master       imem,
   output logic               valid_out,
   output logic               branch_predicted_taken_out,
   output logic [31:0]        pc_out,
   output logic [31:0]        instr_out
);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DISCARD} state_t;

   state_t      r_state,     w_state;
   logic [31:0] r_addr,      w_addr;
   logic [31:0] r_pend,      w_pend;
   logic [31:0] r_buf_pc,    w_buf_pc;
   logic [31:0] r_buf_instr, w_buf_instr;
   logic        r_buf_tk,    w_buf_tk;
   logic        r_valid,     w_valid;
   logic        r_tk,        w_tk;
   logic [31:0] r_pc,        w_pc;
   logic [31:0] r_instr,     w_instr;

   logic        w_read;
   logic        w_done;
   logic [31:0] w_data;
   logic [6:0]  w_opcode;
   logic [31:0] w_jimm;
   logic [31:0] w_bimm;
   logic        w_pred_tk;
   logic [31:0] w_next;
   logic [31:0] w_redir_pc;

   assign w_read     = reset_n && (r_state != S_HOLD);
   assign w_done     = w_read && imem.instr_ready_in;
   assign w_data     = imem.instr_read_value_in;
   assign w_opcode   = w_data[6:0];
   assign w_jimm     = {{12{w_data[31]}}, w_data[19:12], w_data[20], w_data[30:21], 1'b0};
   assign w_bimm     = {{20{w_data[31]}}, w_data[7], w_data[30:25], w_data[11:8], 1'b0};
   assign w_redir_pc = redirect_pc_in & 32'hFFFF_FFFC;

   assign imem.instr_address_out = r_addr;
   assign imem.instr_read_out    = w_read;

   assign valid_out                  = r_valid;
   assign branch_predicted_taken_out = r_tk;
   assign pc_out                     = r_pc;
   assign instr_out                  = r_instr;

   always_comb begin
      w_pred_tk = 1'b0;
      w_next    = r_addr + 32'd4;
      if (w_opcode == 7'b1101111) begin
         w_pred_tk = 1'b1;
         w_next    = r_addr + w_jimm;
      end else if (w_opcode == 7'b1100011 && w_data[31]) begin
         w_pred_tk = 1'b1;
         w_next    = r_addr + w_bimm;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_addr      = r_addr;
      w_pend      = r_pend;
      w_buf_pc    = r_buf_pc;
      w_buf_instr = r_buf_instr;
      w_buf_tk    = r_buf_tk;
      w_valid     = r_valid;
      w_tk        = r_tk;
      w_pc        = r_pc;
      w_instr     = r_instr;

      if (redirect_in) begin
         w_valid = 1'b0;
         // A read stuck waiting must finish at its old address before we move on.
         if (r_state == S_HOLD || w_done) begin
            w_addr  = w_redir_pc;
            w_state = S_FETCH;
         end else begin
            w_pend  = w_redir_pc;
            w_state = S_DISCARD;
         end
      end else begin
         unique case (r_state)
            S_FETCH: begin
               if (w_done) begin
                  w_addr = w_next & 32'hFFFF_FFFC;
                  if (!stall_in) begin
                     w_pc    = r_addr;
                     w_instr = w_data;
                     w_tk    = w_pred_tk;
                     w_valid = 1'b1;
                  end else if (!flush_in) begin
                     w_buf_pc    = r_addr;
                     w_buf_instr = w_data;
                     w_buf_tk    = w_pred_tk;
                     w_state     = S_HOLD;
                  end
               end else if (!stall_in) begin
                  w_valid = 1'b0;
               end
            end
            S_HOLD: begin
               if (flush_in) begin
                  w_state = S_FETCH;
               end else if (!stall_in) begin
                  w_pc    = r_buf_pc;
                  w_instr = r_buf_instr;
                  w_tk    = r_buf_tk;
                  w_valid = 1'b1;
                  w_state = S_FETCH;
               end
            end
            S_DISCARD: begin
               if (w_done) begin
                  w_addr  = r_pend;
                  w_state = S_FETCH;
               end
               if (!stall_in) w_valid = 1'b0;
            end
            default: w_state = S_FETCH;
         endcase
         if (flush_in && !stall_in) begin
            w_valid = 1'b0;
            w_tk    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_FETCH;
         r_addr      <= RESET_PC;
         r_pend      <= '0;
         r_buf_pc    <= '0;
         r_buf_instr <= NOP;
         r_buf_tk    <= 1'b0;
         r_valid     <= 1'b0;
         r_tk        <= 1'b0;
         r_pc        <= '0;
         r_instr     <= NOP;
      end else begin
         r_state     <= w_state;
         r_addr      <= w_addr;
         r_pend      <= w_pend;
         r_buf_pc    <= w_buf_pc;
         r_buf_instr <= w_buf_instr;
         r_buf_tk    <= w_buf_tk;
         r_valid     <= w_valid;
         r_tk        <= w_tk;
         r_pc        <= w_pc;
         r_instr     <= w_instr;
      end
   end
endmodule

// File: tb/tb_rv32_fetch.sv
// Bench for rv32_fetch: queue-based reference model checked every cycle,
// plus directed scenarios with literal expected PCs and predictions.
module tb_rv32_fetch;
   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] JAL16  = 32'h0100_006F;
   localparam logic [31:0] BEQM8  = 32'hFE00_0CE3;
   localparam logic [31:0] BEQP8  = 32'h0000_0463;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        stall_in = 1'b0;
   logic        flush_in = 1'b0;
   logic        redirect_in = 1'b0;
   logic [31:0] redirect_pc_in = '0;
   logic        valid_out, branch_predicted_taken_out;
   logic [31:0] pc_out, instr_out;
   logic [31:0] mem300 = BEQM8;

   int n_chk = 0;
   int n_err = 0;

   rv32_fetch_if imem ();

   rv32_fetch #(.RESET_PC(RST_PC)) dut (
      .clk                        (clk),
      .reset_n                    (reset_n),
      .stall_in                   (stall_in),
      .flush_in                   (flush_in),
      .redirect_in                (redirect_in),
      .redirect_pc_in             (redirect_pc_in),
      .imem                       (imem),
      .valid_out                  (valid_out),
      .branch_predicted_taken_out (branch_predicted_taken_out),
      .pc_out                     (pc_out),
      .instr_out                  (instr_out)
   );

   always #5 clk = ~clk;

   // Instruction memory: NOP everywhere except the words used by the scenarios.
   assign imem.instr_read_value_in = (imem.instr_address_out == 32'h200) ? JAL16 :
                                     (imem.instr_address_out == 32'h300) ? mem300 : NOP;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h200) return JAL16;
      if (a == 32'h300) return mem300;
      return NOP;
   endfunction

   function automatic void predict(input logic [31:0] a, input logic [31:0] w,
                                   output logic tk, output logic [31:0] nx);
      logic [31:0] imm;
      tk  = 1'b0;
      imm = 32'd4;
      if ((w & 32'h7F) == 32'h6F) begin
         tk  = 1'b1;
         imm = (((w >> 21) & 32'h3FF) << 1) | (((w >> 20) & 32'h1) << 11) |
               (((w >> 12) & 32'hFF) << 12);
         if (w[31]) imm = imm - 32'h0010_0000;
      end else if ((w & 32'h7F) == 32'h63 && w[31]) begin
         tk  = 1'b1;
         imm = (((w >> 8) & 32'hF) << 1) | (((w >> 25) & 32'h3F) << 5) |
               (((w >> 7) & 32'h1) << 11);
         imm = imm - 32'h0000_1000;
      end
      nx = a + imm;
   endfunction

   typedef struct {logic [31:0] pc; logic [31:0] instr; logic tk;} ent_t;
   ent_t        q[$];
   logic        m_drop = 1'b0;
   logic [31:0] m_tgt = '0;
   logic [31:0] m_addr = RST_PC;
   logic        e_valid = 1'b0;
   logic        e_tk = 1'b0;
   logic [31:0] e_pc = '0;
   logic [31:0] e_instr = NOP;

   always @(posedge clk or negedge reset_n) begin
      logic        done, tk;
      logic [31:0] nx, w;
      ent_t        e;
      if (!reset_n) begin
         q.delete();
         m_drop = 1'b0;  m_addr = RST_PC;
         e_valid = 1'b0; e_tk = 1'b0; e_pc = '0; e_instr = NOP;
      end else begin
         done = (q.size() == 0) && imem.instr_ready_in;
         if (redirect_in) begin
            e_valid = 1'b0;
            q.delete();
            if (q.size() == 0 && !imem.instr_ready_in && !done) begin
               m_drop = 1'b1; m_tgt = redirect_pc_in & 32'hFFFF_FFFC;
            end else begin
               m_drop = 1'b0; m_addr = redirect_pc_in & 32'hFFFF_FFFC;
            end
         end else if (m_drop) begin
            if (done) begin m_addr = m_tgt; m_drop = 1'b0; end
            if (!stall_in) e_valid = 1'b0;
         end else if (q.size() != 0) begin
            if (flush_in) q.delete();
            else if (!stall_in) begin
               e = q.pop_front();
               e_pc = e.pc; e_instr = e.instr; e_tk = e.tk; e_valid = 1'b1;
            end
         end else if (done) begin
            w = mem_word(m_addr);
            predict(m_addr, w, tk, nx);
            if (!stall_in) begin
               e_pc = m_addr; e_instr = w; e_tk = tk; e_valid = 1'b1;
            end else if (!flush_in) begin
               q.push_back('{pc: m_addr, instr: w, tk: tk});
            end
            m_addr = nx & 32'hFFFF_FFFC;
         end else if (!stall_in) begin
            e_valid = 1'b0;
         end
         if (!redirect_in && flush_in && !stall_in) begin
            e_valid = 1'b0; e_tk = 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("valid_out", 32'(valid_out), 32'(e_valid));
      chk("pred_taken", 32'(branch_predicted_taken_out), 32'(e_tk));
      chk("pc_out", pc_out, e_pc);
      chk("instr_out", instr_out, e_instr);
      chk("instr_address", imem.instr_address_out, m_addr);
      chk("instr_read", 32'(imem.instr_read_out), 32'(reset_n && q.size() == 0));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic redir(input logic [31:0] a);
      redirect_in = 1'b1;
      redirect_pc_in = a;
      cyc();
      redirect_in = 1'b0;
   endtask

   task automatic expect_valid(input logic [31:0] pc, input logic tk, input logic [31:0] ins);
      bit seen = 0;
      for (int unsigned i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (valid_out === 1'b1) begin
            seen = 1;
            chk("lit_pc", pc_out, pc);
            chk("lit_taken", 32'(branch_predicted_taken_out), 32'(tk));
            chk("lit_instr", instr_out, ins);
         end
      end
      if (!seen) begin
         n_chk++; n_err++;
         $display("FAIL lit_wait: no valid_out within 20 cycles, wanted pc %h", pc);
      end
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_valid"}, 32'(valid_out), 32'd0);
      chk({nm, "_taken"}, 32'(branch_predicted_taken_out), 32'd0);
      chk({nm, "_pc"}, pc_out, 32'd0);
      chk({nm, "_instr"}, instr_out, NOP);
      chk({nm, "_read"}, 32'(imem.instr_read_out), 32'd0);
      chk({nm, "_addr"}, imem.instr_address_out, RST_PC);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
      $fatal(1);
   end

   initial begin
      imem.instr_ready_in = 1'b1;
      cyc(); cyc();
      @(negedge clk);
      chk_reset_outputs("rst0");
      cyc();
      reset_n = 1'b1;
      expect_valid(32'h100, 1'b0, NOP);
      expect_valid(32'h104, 1'b0, NOP);
      expect_valid(32'h108, 1'b0, NOP);

      redir(32'h200);
      expect_valid(32'h200, 1'b1, JAL16);
      expect_valid(32'h210, 1'b0, NOP);

      redir(32'h300);
      expect_valid(32'h300, 1'b1, BEQM8);
      expect_valid(32'h2F8, 1'b0, NOP);
      mem300 = BEQP8;
      redir(32'h300);
      expect_valid(32'h300, 1'b0, BEQP8);
      expect_valid(32'h304, 1'b0, NOP);

      redir(32'h400);
      stall_in = 1'b1;
      cyc();
      @(negedge clk);
      chk("stall_read_low", 32'(imem.instr_read_out), 32'd0);
      chk("stall_valid_low", 32'(valid_out), 32'd0);
      cyc(); cyc();
      stall_in = 1'b0;
      expect_valid(32'h400, 1'b0, NOP);
      expect_valid(32'h404, 1'b0, NOP);
      expect_valid(32'h408, 1'b0, NOP);

      redir(32'h500);
      imem.instr_ready_in = 1'b0;
      cyc();
      redirect_in = 1'b1;
      redirect_pc_in = 32'h803;
      cyc();
      redirect_in = 1'b0;
      @(negedge clk);
      chk("discard_addr", imem.instr_address_out, 32'h500);
      chk("discard_read", 32'(imem.instr_read_out), 32'd1);
      cyc(); cyc();
      imem.instr_ready_in = 1'b1;
      cyc();
      @(negedge clk);
      chk("discard_drop", 32'(valid_out), 32'd0);
      chk("discard_next", imem.instr_address_out, 32'h800);
      expect_valid(32'h800, 1'b0, NOP);

      redir(32'h600);
      stall_in = 1'b1;
      cyc();
      stall_in = 1'b0;
      flush_in = 1'b1;
      cyc();
      flush_in = 1'b0;
      expect_valid(32'h604, 1'b0, NOP);

      redir(32'hFFFF_FFFC);
      expect_valid(32'hFFFF_FFFC, 1'b0, NOP);
      expect_valid(32'h0000_0000, 1'b0, NOP);

      expect_valid(32'h4, 1'b0, NOP);
      imem.instr_ready_in = 1'b0;
      cyc();
      #2 reset_n = 1'b0;
      #1 chk_reset_outputs("rst_mid");
      imem.instr_ready_in = 1'b1;
      cyc(); cyc();
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_first", imem.instr_address_out, RST_PC);
      expect_valid(32'h100, 1'b0, NOP);

      redir(32'h700);
      expect_valid(32'h700, 1'b0, NOP);
      expect_valid(32'h704, 1'b0, NOP);
      stall_in = 1'b1;
      cyc();
      #2 reset_n = 1'b0;
      #1 chk_reset_outputs("rst_hold");
      stall_in = 1'b0;
      cyc(); cyc();
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_hold_first", imem.instr_address_out, RST_PC);
      expect_valid(32'h100, 1'b0, NOP);
      cyc(); cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
